// File: rtl/loop_uhat_sparse_udiv_93ns_6ns_seq.sv
// Restoring radix-2 unsigned divider, one quotient bit per enabled clock.
// Recovers quotient/remainder of a 93-bit product divided by its 6-bit factor.
module loop_uhat_sparse_udiv_93ns_6ns_seq #(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 93,
    parameter int din1_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  ready,
    output logic                  done,
    output logic [din0_WIDTH-1:0] quot,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  div_zero
);

    // ID is an instance tag only; folding it in with weight zero keeps it referenced.
    localparam int N  = din0_WIDTH + 0 * ID;
    localparam int M  = din1_WIDTH;
    localparam int CW = $clog2(N);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [N-1:0]  shift_reg;
    logic [M-1:0]  div_reg;
    logic [M:0]    p_reg;

    logic [M:0]    p_shift;
    logic [M:0]    p_sub;
    logic [M:0]    p_next;
    logic          q_bit;
    logic [N-1:0]  shift_next;
    logic          accept;

    assign ready  = (state == S_IDLE) || (state == S_DONE);
    assign done   = (state == S_DONE);
    assign accept = start && ready;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        p_shift    = {p_reg[M-1:0], shift_reg[N-1]};
        p_sub      = p_shift - {1'b0, div_reg};
        q_bit      = (p_shift >= {1'b0, div_reg});
        p_next     = q_bit ? p_sub : p_shift;
        shift_next = {shift_reg[N-2:0], q_bit};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            shift_reg <= '0;
            div_reg   <= '0;
            p_reg     <= '0;
            quot      <= '0;
            rem       <= '0;
            div_zero  <= 1'b0;
        end else if (ce) begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        shift_reg <= din0;
                        div_reg   <= din1;
                        p_reg     <= '0;
                        cnt       <= CW'(N - 1);
                        if (din1 == '0) begin
                            // Divide by zero skips iteration and publishes results now.
                            state    <= S_DONE;
                            quot     <= '1;
                            rem      <= din0[M-1:0];
                            div_zero <= 1'b1;
                        end else begin
                            state <= S_ITER;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_ITER: begin
                    shift_reg <= shift_next;
                    p_reg     <= p_next;
                    if (cnt == '0) begin
                        state    <= S_DONE;
                        quot     <= shift_next;
                        rem      <= p_next[M-1:0];
                        div_zero <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_loop_uhat_sparse_udiv_93ns_6ns_seq.sv
// Directed bench for the 93/6 sequential divider: reset, extremes, divide by zero,
// handshake corner cases, ce stalls, mid-operation reset and a short random sweep.
module tb_loop_uhat_sparse_udiv_93ns_6ns_seq;

    localparam int N = 93;
    localparam int M = 6;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         ce = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] din0 = '0;
    logic [M-1:0] din1 = '0;
    logic         ready;
    logic         done;
    logic [N-1:0] quot;
    logic [M-1:0] rem;
    logic         div_zero;

    int n_checks = 0;
    int n_pass   = 0;
    int lat      = 0;

    loop_uhat_sparse_udiv_93ns_6ns_seq #(
        .ID(1), .din0_WIDTH(N), .din1_WIDTH(M)
    ) dut (
        .clk(clk), .reset(reset), .ce(ce), .start(start),
        .din0(din0), .din1(din1), .ready(ready), .done(done),
        .quot(quot), .rem(rem), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One clock: inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        lat++;
    endtask

    task automatic accept_op(input logic [N-1:0] a, input logic [M-1:0] b);
        din0  = a;
        din1  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat   = 1;
    endtask

    task automatic wait_done(input int limit);
        while (done !== 1'b1 && lat < limit) tick();
    endtask

    task automatic chk_res(input string tag, input logic [N-1:0] q, input logic [M-1:0] r,
                           input logic dz);
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_quot"}, quot, q);
        chk({tag, "_rem"}, rem, r);
        chk({tag, "_dz"}, div_zero, dz);
    endtask

    logic [N-1:0] big;
    logic [95:0]  rnd;
    logic [N-1:0] a_r;
    logic [M-1:0] b_r;
    logic [N+M:0] ident;
    int           stall_at;

    initial begin
        reset = 1'b0;
        ce    = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_quot", quot, '0);
        chk("rst_rem", rem, '0);
        chk("rst_dz", div_zero, 1'b0);
        reset = 1'b1;
        tick();
        chk("idle_ready", ready, 1'b1);

        // Basic 1000 / 7
        accept_op(93'd1000, 6'd7);
        chk("iter_ready", ready, 1'b0);
        wait_done(300);
        chk("basic_lat", lat, 94);
        chk_res("basic", 93'd142, 6'd6, 1'b0);
        chk("basic_ready", ready, 1'b1);
        tick();
        chk("basic_done_pulse", done, 1'b0);

        // Extremes
        big = '1;
        accept_op(big, 6'd63);
        wait_done(300);
        chk("max_lat", lat, 94);
        chk_res("max", (big - 93'd7) / 93'd63, 6'd7, 1'b0);
        tick();
        accept_op(93'd5, 6'd6);
        wait_done(300);
        chk_res("small", 93'd0, 6'd5, 1'b0);
        tick();
        accept_op(93'd0, 6'd1);
        wait_done(300);
        chk_res("zero_num", 93'd0, 6'd0, 1'b0);
        tick();

        // Divide by zero
        accept_op(93'h1234, 6'd0);
        wait_done(300);
        chk("dz_lat", lat, 1);
        chk_res("dz", big, 6'h34, 1'b1);
        chk("dz_ready", ready, 1'b1);
        tick();

        // start during ITER is ignored
        accept_op(93'd1000, 6'd7);
        repeat (20) tick();
        din0  = 93'd81;
        din1  = 6'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("iter_start_ready", ready, 1'b0);
        wait_done(300);
        chk("iter_start_lat", lat, 94);
        chk_res("iter_start", 93'd142, 6'd6, 1'b0);

        // Back-to-back accept from DONE
        accept_op(93'd81, 6'd9);
        chk("b2b_done_low", done, 1'b0);
        chk("b2b_held_quot", quot, 93'd142);
        wait_done(300);
        chk("b2b_lat", lat, 94);
        chk_res("b2b", 93'd9, 6'd0, 1'b0);
        tick();

        // ce stall mid-ITER and during DONE
        stall_at = $urandom_range(5, 80);
        accept_op(93'd1000, 6'd7);
        repeat (stall_at) tick();
        ce = 1'b0;
        repeat (10) tick();
        ce = 1'b1;
        wait_done(300);
        chk("stall_lat", lat, 104);
        chk_res("stall", 93'd142, 6'd6, 1'b0);
        ce = 1'b0;
        repeat (5) tick();
        chk_res("stall_done_frozen", 93'd142, 6'd6, 1'b0);
        ce = 1'b1;
        tick();
        chk("stall_exit_done", done, 1'b0);
        chk("stall_exit_ready", ready, 1'b1);

        // Reset mid-operation
        accept_op(93'd1000, 6'd7);
        repeat (39) tick();
        reset = 1'b0;
        #1;
        chk("midrst_quot", quot, '0);
        chk("midrst_rem", rem, '0);
        chk("midrst_ready", ready, 1'b1);
        chk("midrst_done", done, 1'b0);
        chk("midrst_dz", div_zero, 1'b0);
        tick();
        chk("midrst_no_done", done, 1'b0);
        reset = 1'b1;
        tick();
        chk("midrst_idle_done", done, 1'b0);
        accept_op(93'd1000, 6'd7);
        wait_done(300);
        chk("post_rst_lat", lat, 94);
        chk_res("post_rst", 93'd142, 6'd6, 1'b0);
        tick();

        // Random operands against a reference quotient/remainder
        for (int i = 0; i < 12; i++) begin
            rnd = {$urandom, $urandom, $urandom};
            a_r = rnd[N-1:0];
            b_r = M'($urandom_range(0, 63));
            if (i == 3) b_r = '0;
            accept_op(a_r, b_r);
            wait_done(300);
            if (b_r == '0) begin
                chk("rnd_dz_lat", lat, 1);
                chk_res("rnd_dz", big, a_r[M-1:0], 1'b1);
            end else begin
                chk("rnd_lat", lat, 94);
                chk_res("rnd", a_r / N'(b_r), M'(a_r % N'(b_r)), 1'b0);
                ident = (N+M+1)'(quot) * (N+M+1)'(b_r) + (N+M+1)'(rem);
                chk("rnd_identity", ident[N-1:0], a_r);
                chk("rnd_rem_lt", (rem < b_r), 1'b1);
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
